// File: rtl/mrmw_pkg.sv
// ============================================================================
// Module      : mrmw_pkg
// Description : Shared constants and helpers for the multi-read/multi-write RAM
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mrmw_pkg;

    localparam int RD_ADDR_REG = 0;
    localparam int RD_DATA_REG = 1;

    function automatic int lane_count(input int data_width);
        return data_width / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mrmw_rd_port.sv
// ============================================================================
// Module      : mrmw_rd_port
// Description : One read port of the shared RAM, address- or data-registered
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mrmw_rd_port
    import mrmw_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int RD_MODE    = RD_ADDR_REG
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] mem [DEPTH],
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid
);

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_ok;
    logic [DATA_WIDTH-1:0] sel_word;

    assign sel_word = sel_ok ? mem[sel_addr] : '0;

    generate
        if ((2 ** ADDR_WIDTH) > DEPTH) begin : g_range_chk
            assign sel_ok = (sel_addr < ADDR_WIDTH'(DEPTH));
        end else begin : g_no_range_chk
            assign sel_ok = 1'b1;
        end
    endgenerate

    generate
        if (RD_MODE == RD_DATA_REG) begin : g_data_reg
            logic [DATA_WIDTH-1:0] rdata_q;

            assign sel_addr = raddr;

            // Array is sampled before this edge's writes land: read-first.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    rdata_q <= '0;
                end else if (ren) begin
                    rdata_q <= sel_word;
                end
            end

            assign rdata = rdata_q;
        end else begin : g_addr_reg
            logic [ADDR_WIDTH-1:0] raddr_q;

            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    raddr_q <= '0;
                end else if (ren) begin
                    raddr_q <= raddr;
                end
            end

            assign sel_addr = raddr_q;
            assign rdata    = sel_word;
        end
    endgenerate

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rvalid <= 1'b0;
        end else if (ren) begin
            rvalid <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mrmw_raddr.sv
// ============================================================================
// Module      : mrmw_raddr
// Description : Parametrised multi-read multi-write RAM with byte enables
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mrmw_raddr
    import mrmw_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_RD     = 1,
    parameter int NUM_WR     = 1,
    parameter int RD_MODE    = RD_ADDR_REG
) (
    input  logic                                      clock,
    input  logic                                      resetn,
    input  logic [NUM_WR-1:0]                         wen,
    input  logic [NUM_WR*lane_count(DATA_WIDTH)-1:0]  wbe,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]              waddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]              wdata,
    input  logic [NUM_RD-1:0]                         ren,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]              raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0]              rdata,
    output logic [NUM_RD-1:0]                         rvalid
);

    localparam int LANES = lane_count(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [NUM_WR-1:0]     wr_ok;

    generate
        for (genvar p = 0; p < NUM_WR; p++) begin : g_wr_range
            if ((2 ** ADDR_WIDTH) > DEPTH) begin : g_range_chk
                assign wr_ok[p] = (waddr[p*ADDR_WIDTH +: ADDR_WIDTH] < ADDR_WIDTH'(DEPTH));
            end else begin : g_no_range_chk
                assign wr_ok[p] = 1'b1;
            end
        end
    endgenerate

    // Ascending port order: a later non-blocking update to the same lane wins.
    always_ff @(posedge clock) begin
        for (int p = 0; p < NUM_WR; p++) begin
            for (int b = 0; b < LANES; b++) begin
                if (wen[p] && wbe[p*LANES + b] && wr_ok[p]) begin
                    mem[waddr[p*ADDR_WIDTH +: ADDR_WIDTH]][b*8 +: 8] <= wdata[p*DATA_WIDTH + b*8 +: 8];
                end
            end
        end
    end

    generate
        for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
            mrmw_rd_port #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (DEPTH),
                .ADDR_WIDTH (ADDR_WIDTH),
                .RD_MODE    (RD_MODE)
            ) u_rd_port (
                .clock  (clock),
                .resetn (resetn),
                .ren    (ren[r]),
                .raddr  (raddr[r*ADDR_WIDTH +: ADDR_WIDTH]),
                .mem    (mem),
                .rdata  (rdata[r*DATA_WIDTH +: DATA_WIDTH]),
                .rvalid (rvalid[r])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mrmw_raddr.sv
// ============================================================================
// Module      : tb_mrmw_raddr
// Description : Directed and random checks of mrmw_raddr in both read modes
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mrmw_raddr;

    logic clock = 1'b0;
    logic resetn;

    // DEPTH=4 pair (address-registered and data-registered share stimulus)
    logic [1:0]  wen;
    logic [7:0]  wbe;
    logic [3:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  ren;
    logic [3:0]  raddr;
    logic [63:0] rdata_a, rdata_d;
    logic [1:0]  rvalid_a, rvalid_d;

    // DEPTH=5 pair for the random soak
    logic [1:0]  s_wen;
    logic [7:0]  s_wbe;
    logic [5:0]  s_waddr;
    logic [63:0] s_wdata;
    logic [1:0]  s_ren;
    logic [5:0]  s_raddr;
    logic [63:0] s_rdata_a, s_rdata_d;
    logic [1:0]  s_rvalid_a, s_rvalid_d;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mrmw_raddr #(.DATA_WIDTH(32), .DEPTH(4), .NUM_RD(2), .NUM_WR(2), .RD_MODE(0)) dut_a (
        .clock(clock), .resetn(resetn), .wen(wen), .wbe(wbe), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a));

    mrmw_raddr #(.DATA_WIDTH(32), .DEPTH(4), .NUM_RD(2), .NUM_WR(2), .RD_MODE(1)) dut_d (
        .clock(clock), .resetn(resetn), .wen(wen), .wbe(wbe), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr(raddr), .rdata(rdata_d), .rvalid(rvalid_d));

    mrmw_raddr #(.DATA_WIDTH(32), .DEPTH(5), .NUM_RD(2), .NUM_WR(2), .RD_MODE(0)) dut_sa (
        .clock(clock), .resetn(resetn), .wen(s_wen), .wbe(s_wbe), .waddr(s_waddr), .wdata(s_wdata),
        .ren(s_ren), .raddr(s_raddr), .rdata(s_rdata_a), .rvalid(s_rvalid_a));

    mrmw_raddr #(.DATA_WIDTH(32), .DEPTH(5), .NUM_RD(2), .NUM_WR(2), .RD_MODE(1)) dut_sd (
        .clock(clock), .resetn(resetn), .wen(s_wen), .wbe(s_wbe), .waddr(s_waddr), .wdata(s_wdata),
        .ren(s_ren), .raddr(s_raddr), .rdata(s_rdata_d), .rvalid(s_rvalid_d));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wen = '0; wbe = '0; ren = '0;
    endtask

    task automatic set_wr(input int p, input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        wen[p]          = 1'b1;
        wbe[p*4 +: 4]   = be;
        waddr[p*2 +: 2] = a;
        wdata[p*32 +: 32] = d;
    endtask

    // Behavioural model for the DEPTH=5 soak
    logic [31:0] mm [5];
    logic [2:0]  qa [2];
    logic [31:0] exp_d [2];
    logic        vld [2];

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        idle(); waddr = '0; wdata = '0; raddr = '0;
        s_wen = '0; s_wbe = '0; s_waddr = '0; s_wdata = '0; s_ren = '0; s_raddr = '0;
        step(); step();

        chk("reset_rvalid_a", 64'(rvalid_a), 64'h0);
        chk("reset_rvalid_d", 64'(rvalid_d), 64'h0);
        chk("reset_rdata_d", rdata_d, 64'h0);

        resetn = 1'b1;
        ren = 2'b01; raddr = 4'h0;
        step();
        idle();
        chk("first_ren_rvalid_a", 64'(rvalid_a), 64'h1);
        chk("first_ren_rvalid_d", 64'(rvalid_d), 64'h1);
        chk("soak_rvalid_idle", 64'(s_rvalid_a), 64'h0);

        // Byte enables
        set_wr(0, 2'd2, 32'h11223344, 4'hF); step();
        set_wr(0, 2'd2, 32'hAABBCCDD, 4'b0101); step();
        idle(); ren = 2'b11; raddr = {2'd2, 2'd2}; step();
        idle();
        chk("be_a0", 64'(rdata_a[31:0]),  64'h11BB33DD);
        chk("be_a1", 64'(rdata_a[63:32]), 64'h11BB33DD);
        chk("be_d0", 64'(rdata_d[31:0]),  64'h11BB33DD);
        chk("be_d1", 64'(rdata_d[63:32]), 64'h11BB33DD);
        chk("both_rvalid_a", 64'(rvalid_a), 64'h3);

        // Write collision: highest port wins
        set_wr(0, 2'd1, 32'h1, 4'hF);
        set_wr(1, 2'd1, 32'h2, 4'hF);
        step();
        idle(); ren = 2'b11; raddr = {2'd1, 2'd1}; step();
        idle();
        chk("coll_a0", 64'(rdata_a[31:0]),  64'h2);
        chk("coll_a1", 64'(rdata_a[63:32]), 64'h2);
        chk("coll_d0", 64'(rdata_d[31:0]),  64'h2);

        // Mode contrast
        set_wr(0, 2'd3, 32'h5, 4'hF); step();
        idle(); ren = 2'b01; raddr = 4'h3; step();
        idle();
        chk("mode_pre_a", 64'(rdata_a[31:0]), 64'h5);
        chk("mode_pre_d", 64'(rdata_d[31:0]), 64'h5);
        set_wr(0, 2'd3, 32'h9, 4'hF); step();
        idle();
        chk("mode_post_a", 64'(rdata_a[31:0]), 64'h9);
        chk("mode_post_d", 64'(rdata_d[31:0]), 64'h5);
        chk("mode_port1_a", 64'(rdata_a[63:32]), 64'h2);

        // Same-edge read and write
        set_wr(0, 2'd0, 32'h4, 4'hF); step();
        idle();
        set_wr(0, 2'd0, 32'h7, 4'hF); ren = 2'b01; raddr = 4'h0; step();
        idle();
        chk("same_edge_a", 64'(rdata_a[31:0]), 64'h7);
        chk("same_edge_d", 64'(rdata_d[31:0]), 64'h4);

        // Asynchronous reset mid-operation, memory kept
        resetn = 1'b0;
        #1;
        chk("mid_reset_rvalid_a", 64'(rvalid_a), 64'h0);
        chk("mid_reset_rvalid_d", 64'(rvalid_d), 64'h0);
        chk("mid_reset_rdata_d", rdata_d, 64'h0);
        step();
        resetn = 1'b1;
        ren = 2'b01; raddr = 4'h3; step();
        idle();
        chk("mem_kept_a", 64'(rdata_a[31:0]), 64'h9);
        chk("mem_kept_d", 64'(rdata_d[31:0]), 64'h9);

        // Soak: preload all five words so the model is fully defined
        for (int i = 0; i < 5; i++) begin
            s_wen = 2'b01; s_wbe = 8'h0F; s_waddr = 6'(i);
            s_wdata = {32'h0, 32'hC0DE0000 + 32'(i)};
            mm[i] = 32'hC0DE0000 + 32'(i);
            step();
        end
        s_wen = '0;
        for (int r = 0; r < 2; r++) begin
            qa[r] = 3'd0; exp_d[r] = 32'h0; vld[r] = 1'b0;
        end

        for (int c = 0; c < 500; c++) begin
            s_wen   = 2'($urandom);
            s_wbe   = 8'($urandom);
            s_waddr = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            s_wdata = {$urandom, $urandom};
            s_ren   = 2'($urandom);
            s_raddr = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            for (int r = 0; r < 2; r++) begin
                if (s_ren[r]) begin
                    vld[r]   = 1'b1;
                    qa[r]    = s_raddr[r*3 +: 3];
                    exp_d[r] = (qa[r] < 3'd5) ? mm[qa[r]] : 32'h0;
                end
            end
            for (int p = 0; p < 2; p++) begin
                for (int b = 0; b < 4; b++) begin
                    if (s_wen[p] && s_wbe[p*4 + b] && (s_waddr[p*3 +: 3] < 3'd5))
                        mm[s_waddr[p*3 +: 3]][b*8 +: 8] = s_wdata[p*32 + b*8 +: 8];
                end
            end
            step();
            for (int r = 0; r < 2; r++) begin
                chk("soak_rvalid_a", 64'(s_rvalid_a[r]), 64'(vld[r]));
                chk("soak_rvalid_d", 64'(s_rvalid_d[r]), 64'(vld[r]));
                if (vld[r]) begin
                    chk("soak_rdata_a", 64'(s_rdata_a[r*32 +: 32]),
                        64'((qa[r] < 3'd5) ? mm[qa[r]] : 32'h0));
                    chk("soak_rdata_d", 64'(s_rdata_d[r*32 +: 32]), 64'(exp_d[r]));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
